// File: rtl/adc_spi_responder.sv
// Three-wire SPI target standing in for the ADC configuration port.
// SPI pins are sampled on Clock; the top level owns the SDIO tristate.
module adc_spi_responder #(
    parameter int unsigned REG_COUNT    = 16,
    parameter logic [7:0]  CHIP_ID      = 8'hA5,
    parameter logic [7:0]  CONFIG_RESET = 8'h18
) (
    input  logic        Clock,
    input  logic        Reset_N,
    input  logic        ADC_sclk,
    input  logic        ADC_ss_n,
    input  logic        SDIO_in,
    output logic        SDIO_out,
    output logic        SDIO_oe,
    output logic        Reg_Write_Strobe,
    output logic [12:0] Reg_Write_Addr,
    output logic [7:0]  Reg_Write_Data,
    output logic        Frame_Error
);

    localparam int          AW      = (REG_COUNT > 2) ? $clog2(REG_COUNT) : 1;
    localparam logic [12:0] REG_LIM = 13'(REG_COUNT);

    typedef enum logic [1:0] {IDLE, HEADER, WRITE_DATA, READ_DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sclk_sync, ss_sync, sdi_sync;
    logic        sclk_q, ss_q, sdi_q;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [3:0]  bit_cnt;
    logic        rnw;
    logic [11:0] hdr_addr;
    logic [12:0] hdr_next, addr;
    logic [6:0]  wr_sh;
    logic [7:0]  wr_next, rd_sh;
    logic        frame_err_d;
    logic [7:0]  regs [REG_COUNT];

    function automatic logic [7:0] reg_rd(input logic [12:0] a);
        if (a == 13'd1)        return CHIP_ID;
        else if (a < REG_LIM)  return regs[a[AW-1:0]];
        else                   return 8'h00;
    endfunction

    function automatic logic writable(input logic [12:0] a);
        return (a != 13'd1) && (a < REG_LIM);
    endfunction

    // Two sync flops, then a registered edge detect; SCLK edges are
    // masked while select is high, so a coincident ss_n rise always wins.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            sclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            sdi_sync  <= 2'b00;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
            sdi_q     <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], ADC_sclk};
            ss_sync   <= {ss_sync[0], ADC_ss_n};
            sdi_sync  <= {sdi_sync[0], SDIO_in};
            sclk_q    <= sclk_sync[1];
            ss_q      <= ss_sync[1];
            sdi_q     <= sdi_sync[1];
            sclk_rise <= sclk_sync[1] & ~sclk_q & ~ss_sync[1];
            sclk_fall <= ~sclk_sync[1] & sclk_q & ~ss_sync[1];
            ss_rise   <= ss_sync[1] & ~ss_q;
            ss_fall   <= ~ss_sync[1] & ss_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        hdr_next    = {hdr_addr, sdi_q};
        wr_next     = {wr_sh, sdi_q};
        frame_err_d = ss_rise && ((state_q == HEADER) ||
                      ((state_q == WRITE_DATA || state_q == READ_DATA) && bit_cnt != 4'd0));
        if (ss_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (ss_fall) state_d = HEADER;
                HEADER:     if (sclk_rise && bit_cnt == 4'd15)
                                state_d = rnw ? READ_DATA : WRITE_DATA;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            SDIO_out         <= 1'b0;
            SDIO_oe          <= 1'b0;
            Reg_Write_Strobe <= 1'b0;
            Reg_Write_Addr   <= '0;
            Reg_Write_Data   <= '0;
            Frame_Error      <= 1'b0;
            bit_cnt          <= '0;
            rnw              <= 1'b0;
            hdr_addr         <= '0;
            addr             <= '0;
            wr_sh            <= '0;
            rd_sh            <= '0;
            for (int i = 0; i < int'(REG_COUNT); i++)
                regs[i] <= (i == 0) ? CONFIG_RESET : 8'h00;
        end else begin
            Reg_Write_Strobe <= 1'b0;
            Frame_Error      <= frame_err_d;
            if (ss_rise) begin
                SDIO_oe  <= 1'b0;
                SDIO_out <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                case (state_q)
                    IDLE: bit_cnt <= '0;
                    HEADER: if (sclk_rise) begin
                        hdr_addr <= hdr_next[11:0];
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd0) rnw <= sdi_q;
                        // Last header bit: reads prefetch byte 0 and point at the next one.
                        if (bit_cnt == 4'd15) begin
                            if (rnw) begin
                                rd_sh <= reg_rd(hdr_next);
                                addr  <= hdr_next + 13'd1;
                            end else begin
                                addr  <= hdr_next;
                            end
                        end
                    end
                    WRITE_DATA: if (sclk_rise) begin
                        wr_sh   <= wr_next[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr + 13'd1;
                            if (writable(addr)) begin
                                regs[addr[AW-1:0]] <= wr_next;
                                Reg_Write_Strobe   <= 1'b1;
                                Reg_Write_Addr     <= addr;
                                Reg_Write_Data     <= wr_next;
                            end
                        end
                    end
                    READ_DATA: begin
                        if (sclk_fall) begin
                            SDIO_out <= rd_sh[7];
                            rd_sh    <= {rd_sh[6:0], 1'b0};
                            SDIO_oe  <= 1'b1;
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                rd_sh   <= reg_rd(addr);
                                addr    <= addr + 13'd1;
                            end
                        end
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: SPI master tasks, register model and
// scoreboard queues for write strobes and read bytes.
module tb_adc_spi_responder;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst_n, sclk, ss_n, sdi;
    logic        sdo, oe, strb, fe;
    logic [12:0] waddr;
    logic [7:0]  wdata;

    int n_chk = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int exp_fe = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] mdl [16];
    wr_t        wr_e;

    always #5 clk = ~clk;

    adc_spi_responder dut (
        .Clock(clk), .Reset_N(rst_n), .ADC_sclk(sclk), .ADC_ss_n(ss_n),
        .SDIO_in(sdi), .SDIO_out(sdo), .SDIO_oe(oe),
        .Reg_Write_Strobe(strb), .Reg_Write_Addr(waddr),
        .Reg_Write_Data(wdata), .Frame_Error(fe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdl_rd(input logic [12:0] a);
        if (a == 13'd1)      return 8'hA5;
        else if (a < 13'd16) return mdl[a[3:0]];
        else                 return 8'h00;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl[0] = 8'h18;
    endtask

    always @(negedge clk) begin
        if (fe) fe_cnt++;
        if (strb) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'(strb), 32'd0);
            end else begin
                wr_e = exp_wr.pop_front();
                chk("wr_addr", 32'(waddr), 32'(wr_e.a));
                chk("wr_data", 32'(wdata), 32'(wr_e.d));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input logic b, output logic r);
        sdi = b;
        #HALF;
        r = sdo;
        sclk = 1'b1;
        #HALF;
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic ss_end();
        #HALF;
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("frame_err", 32'(fe_cnt), 32'(exp_fe));
        chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic send_hdr(input logic rnw, input logic [12:0] a, input int nbits);
        logic [15:0] h;
        logic        r;
        h = {rnw, 2'b00, a};
        for (int i = 0; i < nbits; i++) spi_bit(h[15-i], r);
        chk("oe_hdr", 32'(oe), 32'd0);
    endtask

    task automatic write_frame(input logic [12:0] a, input int n,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0]  d [3];
        logic [7:0]  rx;
        logic [12:0] cur;
        d[0] = d0; d[1] = d1; d[2] = d2;
        ss_begin();
        send_hdr(1'b0, a, 16);
        cur = a;
        for (int j = 0; j < n; j++) begin
            if (cur != 13'd1 && cur < 13'd16) begin
                mdl[cur[3:0]] = d[j];
                exp_wr.push_back({cur, d[j]});
            end
            spi_byte(d[j], rx);
            cur = cur + 13'd1;
        end
        ss_end();
    endtask

    task automatic read_frame(input logic [12:0] a, input int n);
        logic [7:0]  rx, e;
        logic [12:0] cur;
        ss_begin();
        send_hdr(1'b1, a, 16);
        cur = a;
        for (int j = 0; j < n; j++) begin
            exp_rd.push_back(mdl_rd(cur));
            spi_byte(8'h00, rx);
            chk("oe_rd", 32'(oe), 32'd1);
            e = exp_rd.pop_front();
            chk("rd_data", 32'(rx), 32'(e));
            cur = cur + 13'd1;
        end
        ss_end();
    endtask

    initial begin
        logic r;
        rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; sdi = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_strb", 32'(strb), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_fe", 32'(fe), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        read_frame(13'h000, 1);
        write_frame(13'h005, 1, 8'h3C, 8'h00, 8'h00);
        read_frame(13'h005, 1);

        read_frame(13'h001, 1);
        write_frame(13'h001, 1, 8'h00, 8'h00, 8'h00);
        read_frame(13'h001, 1);

        write_frame(13'h002, 3, 8'h11, 8'h22, 8'h33);
        read_frame(13'h002, 3);

        read_frame(13'h0FFF, 1);
        write_frame(13'h1FFF, 2, 8'h77, 8'h5A, 8'h00);
        read_frame(13'h000, 1);
        read_frame(13'h00E, 3);

        // Aborted header and aborted write byte
        ss_begin();
        send_hdr(1'b0, 13'h005, 10);
        exp_fe++;
        ss_end();
        ss_begin();
        send_hdr(1'b0, 13'h003, 16);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
        exp_fe++;
        ss_end();
        read_frame(13'h003, 1);

        // Reset in the middle of a read byte
        write_frame(13'h000, 1, 8'h42, 8'h00, 8'h00);
        ss_begin();
        send_hdr(1'b1, 13'h000, 16);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        chk("oe_pre_rst", 32'(oe), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("oe_async_rst", 32'(oe), 32'd0);
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("waddr_mid_rst", 32'(waddr), 32'd0);
        chk("wdata_mid_rst", 32'(wdata), 32'd0);
        rst_n = 1'b1;
        mdl_reset();
        repeat (4) @(negedge clk);
        read_frame(13'h000, 1);
        read_frame(13'h005, 1);

        chk("rd_leftover", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
